// File: rtl/vga_pkg.sv
// Shared constants and bit-select helper for the packed binary-pixel read path.
package vga_pkg;
    localparam int PIX_PER_FRAME_DEF = 640 * 480;
    localparam int PACK_W            = 8;
    localparam int PHASE_W           = 3;
    localparam int FRAME_CNT_W       = 19;

    // Bit 0 is the oldest pixel written by the capture-side packer.
    function automatic logic sel_bit(input logic [PACK_W-1:0] b,
                                     input logic [PHASE_W-1:0] idx,
                                     input bit                 lsb_first);
        return lsb_first ? b[idx] : b[PHASE_W'(PACK_W-1) - idx];
    endfunction
endpackage

// File: rtl/bit_unpack_slot.sv
// Current-byte slot: holds the byte being shifted out and its bit phase.
import vga_pkg::*;

module bit_unpack_slot #(
    parameter int LSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [PACK_W-1:0]  load_byte,
    input  logic               load_skip,
    input  logic               clear,
    input  logic               advance,
    output logic               cur_valid,
    output logic [PHASE_W-1:0] cnt,
    output logic               last,
    output logic               bit_out
);
    logic [PACK_W-1:0] cur;

    // load_skip: the first bit of load_byte was already emitted by the caller.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= '0;
            cur_valid <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            cur       <= load_byte;
            cur_valid <= 1'b1;
            cnt       <= load_skip ? PHASE_W'(1) : PHASE_W'(0);
        end else if (clear) begin
            cur_valid <= 1'b0;
            cnt       <= '0;
        end else if (advance) begin
            cnt <= cnt + 1'b1;
            if (last) cur_valid <= 1'b0;
        end
    end

    assign last    = (cnt == PHASE_W'(PACK_W-1));
    assign bit_out = sel_bit(cur, cnt, LSB_FIRST != 0);
endmodule

// File: rtl/vga_bitmap_unpacker.sv
// Expands 8:1 packed binary pixels from the SDRAM read FIFO into one VGA pixel per request.
import vga_pkg::*;

module vga_bitmap_unpacker #(
    parameter int PIX_W         = 10,
    parameter int PIX_PER_FRAME = PIX_PER_FRAME_DEF,
    parameter int LSB_FIRST     = 1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iRequest,
    input  logic             iFrame_Start,
    output logic             oRD,
    input  logic [15:0]      iRD_DATA,
    output logic [PIX_W-1:0] oPixel,
    output logic             oPix_Valid,
    output logic             oFrame_Done,
    output logic             oUnderrun,
    output logic             oSync_Err
);
    logic [PACK_W-1:0]      nxt;
    logic                   nxt_valid, pending;
    logic [FRAME_CNT_W-1:0] pix_cnt, pix_base;
    logic                   cur_valid, last, cur_bit;
    logic [PHASE_W-1:0]     cnt;
    logic                   discard, cv_eff, serve_cur, serve_nxt, nxt_take;
    logic                   under_ev, pix_bit, frame_end;
    logic                   unused_hi;

    assign unused_hi = ^iRD_DATA[15:PACK_W];

    always_comb begin
        discard   = iFrame_Start && (cnt != '0);
        cv_eff    = cur_valid && !discard;
        serve_cur = iRequest && cv_eff;
        // A realignment request is answered straight from the prefetched byte.
        serve_nxt = iRequest && discard && nxt_valid;
        nxt_take  = nxt_valid && (!cv_eff || (serve_cur && last));
        under_ev  = iRequest && !serve_cur && !serve_nxt;
        pix_bit   = 1'b0;
        if (serve_cur)      pix_bit = cur_bit;
        else if (serve_nxt) pix_bit = sel_bit(nxt, PHASE_W'(0), LSB_FIRST != 0);
        pix_base  = iFrame_Start ? '0 : pix_cnt;
        frame_end = iRequest && (pix_base == FRAME_CNT_W'(PIX_PER_FRAME-1));
        // Looks ahead at the slot being freed this cycle so refill starts immediately.
        oRD       = iRST_N && !pending && (!nxt_valid || nxt_take);
    end

    bit_unpack_slot #(.LSB_FIRST(LSB_FIRST)) u_slot (
        .clk       (iCLK),
        .rst_n     (iRST_N),
        .load      (nxt_take),
        .load_byte (nxt),
        .load_skip (serve_nxt),
        .clear     (discard),
        .advance   (serve_cur),
        .cur_valid (cur_valid),
        .cnt       (cnt),
        .last      (last),
        .bit_out   (cur_bit)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            nxt         <= '0;
            nxt_valid   <= 1'b0;
            pending     <= 1'b0;
            pix_cnt     <= '0;
            oPixel      <= '0;
            oPix_Valid  <= 1'b0;
            oFrame_Done <= 1'b0;
            oUnderrun   <= 1'b0;
            oSync_Err   <= 1'b0;
        end else begin
            pending <= oRD;
            if (nxt_take) nxt_valid <= 1'b0;
            if (pending) begin
                nxt       <= iRD_DATA[PACK_W-1:0];
                nxt_valid <= 1'b1;
            end
            if (iRequest) pix_cnt <= frame_end ? '0 : pix_base + 1'b1;
            else          pix_cnt <= pix_base;
            oPix_Valid  <= iRequest;
            oPixel      <= {PIX_W{pix_bit}};
            oFrame_Done <= frame_end;
            if (under_ev) oUnderrun <= 1'b1;
            if (iFrame_Start && (pix_cnt != '0)) oSync_Err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_bitmap_unpacker.sv
// Directed bench: two unpacker instances (LSB-first/64-pixel frame and MSB-first) with FIFO models.
module tb_vga_bitmap_unpacker;
    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, fs = 1'b0;
    logic [15:0] rd_a = '0, rd_b = '0;
    logic        rd_en_a, rd_en_b;
    logic [9:0]  pix_a, pix_b;
    logic        val_a, val_b, fd_a, fd_b, ur_a, ur_b, se_a, se_b;
    logic [7:0]  qa[$], qb[$];
    int          total = 0, bad = 0;
    int          rd_cnt_a = 0, b2b_a = 0;
    logic        prev_rd_a = 1'b0;

    vga_bitmap_unpacker #(.PIX_W(10), .PIX_PER_FRAME(64), .LSB_FIRST(1)) dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iRequest(req), .iFrame_Start(fs),
        .oRD(rd_en_a), .iRD_DATA(rd_a), .oPixel(pix_a), .oPix_Valid(val_a),
        .oFrame_Done(fd_a), .oUnderrun(ur_a), .oSync_Err(se_a));

    vga_bitmap_unpacker #(.PIX_W(10), .LSB_FIRST(0)) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iRequest(req), .iFrame_Start(fs),
        .oRD(rd_en_b), .iRD_DATA(rd_b), .oPixel(pix_b), .oPix_Valid(val_b),
        .oFrame_Done(fd_b), .oUnderrun(ur_b), .oSync_Err(se_b));

    always #5 clk = ~clk;

    // Legacy-mode FIFOs: data appears the cycle after the read strobe; zeros when empty.
    always @(posedge clk) begin
        if (rd_en_a) begin
            if (qa.size() > 0) rd_a <= {8'hA5, qa.pop_front()};
            else               rd_a <= 16'hA500;
            rd_cnt_a++;
            if (prev_rd_a) b2b_a++;
        end
        prev_rd_a = rd_en_a;
        if (rd_en_b) begin
            if (qb.size() > 0) rd_b <= {8'h5A, qb.pop_front()};
            else               rd_b <= 16'h5A00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0; fs = 1'b0;
        qa.delete(); qb.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit pat_a[24] = '{1,0,0,0,0,0,0,0, 0,1,1,1,1,1,1,1, 0,1,0,1,0,1,0,1};
        bit pat_b[16] = '{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1};
        int fd_pulses, served, rd_base, b2b_base;

        // Reset state
        do_reset();
        chk("rst_pixel", 32'(pix_a), 0);
        chk("rst_valid", 32'(val_a), 0);
        chk("rst_rd",    32'(rd_en_a), 0);
        chk("rst_fdone", 32'(fd_a), 0);
        chk("rst_under", 32'(ur_a), 0);
        chk("rst_sync",  32'(se_a), 0);

        // Continuous stream, zero-bubble byte hand-over, both bit orders
        qa.push_back(8'h01); qa.push_back(8'hFE); qa.push_back(8'hAA);
        qb.push_back(8'h80); qb.push_back(8'h01);
        rst_n = 1'b1;
        #1 chk("rd_first", 32'(rd_en_a), 1);
        @(negedge clk); chk("rd_pending", 32'(rd_en_a), 0);
        @(negedge clk); chk("rd_promote", 32'(rd_en_a), 1);
        @(negedge clk);
        req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("strm_a_pix%0d", i), 32'(pix_a), pat_a[i] ? 32'h3FF : 32'h0);
            chk($sformatf("strm_a_val%0d", i), 32'(val_a), 1);
            if (i < 16) chk($sformatf("strm_b_pix%0d", i), 32'(pix_b), pat_b[i] ? 32'h3FF : 32'h0);
        end
        req = 1'b0;
        chk("strm_under_a", 32'(ur_a), 0);
        chk("strm_under_b", 32'(ur_b), 0);

        // Requests before any byte is held
        do_reset();
        rst_n = 1'b1; req = 1'b1;
        @(negedge clk);
        chk("ur_valid", 32'(val_a), 1);
        chk("ur_pixel", 32'(pix_a), 0);
        chk("ur_flag",  32'(ur_a), 1);
        repeat (6) @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        chk("ur_sticky", 32'(ur_a), 1);

        // 64-pixel frame boundary
        do_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        fd_pulses = 0;
        req = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (fd_a) fd_pulses++;
            if (k == 63) chk("fd_early", 32'(fd_a), 0);
            if (k == 64) chk("fd_last",  32'(fd_a), 1);
        end
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0; req = 1'b0;
        chk("fd_after",      32'(fd_a), 0);
        chk("fd_pulses",     32'(fd_pulses), 1);
        chk("fd_sync_clean", 32'(se_a), 0);
        chk("fd_under",      32'(ur_a), 0);

        // Mid-byte frame start: realign onto the next byte
        do_reset();
        qa.push_back(8'hF8); qa.push_back(8'h01); qa.push_back(8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("sync_pre%0d", i), 32'(pix_a), 0);
        end
        chk("sync_before", 32'(se_a), 0);
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        chk("sync_err",   32'(se_a), 1);
        chk("sync_pixel", 32'(pix_a), 32'h3FF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("sync_post%0d", i), 32'(pix_a), 0);
        end
        req = 1'b0;
        chk("sync_under", 32'(ur_a), 0);

        // Random request audit of read strobes
        do_reset();
        rst_n = 1'b1;
        rd_base = rd_cnt_a; b2b_base = b2b_a;
        repeat (3) @(negedge clk);
        served = 0;
        for (int i = 0; i < 1000; i++) begin
            req = 1'($urandom_range(0, 1));
            if (req) served++;
            @(negedge clk);
        end
        req = 1'b0;
        repeat (4) @(negedge clk);
        chk("aud_held",  32'((rd_cnt_a - rd_base) - served / 8), 2);
        chk("aud_b2b",   32'(b2b_a - b2b_base), 0);
        chk("aud_under", 32'(ur_a), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_bitmap_unpacker.md
Name: vga_bitmap_unpacker

Overview:
- Read-side counterpart of the capture path's 8:1 binary-pixel packer. The packer stores eight thresholded pixels per SDRAM word in bits [7:0]: bit 0 is the oldest pixel, bit 7 the newest.
- This block pulls packed words from the SDRAM read FIFO and emits one pixel per VGA pixel request, expanded to full intensity.
- It sits between the Sdram_Control_4Port RD2 port and VGA_Controller iRed/iGreen/iBlue, replacing the per-pixel Read_DATA2[0] path.
- It cuts read-FIFO traffic by 8x and adds frame-alignment and underrun checking.

Parameters:
- PIX_W, 10, width of the expanded colour output.
- PIX_PER_FRAME, 307200, pixels per frame (640*480); must be a multiple of 8.
- LSB_FIRST, 1, 1 = emit bit 0 first (matches the packer); 0 = emit bit 7 first.

Ports:
- iCLK  in  1  VGA control clock.
- iRST_N  in  1  synchronous active-low reset.
- iRequest  in  1  pixel request from VGA_Controller oRequest; one pixel consumed per cycle high.
- iFrame_Start  in  1  one-cycle pulse coincident with the first request of a frame.
- oRD  out  1  read strobe to the FIFO; data is valid on iRD_DATA the cycle after.
- iRD_DATA  in  16  FIFO read data; only [7:0] is used.
- oPixel  out  PIX_W  expanded pixel: all ones or all zeros.
- oPix_Valid  out  1  high one cycle after each accepted iRequest.
- oFrame_Done  out  1  one-cycle pulse with the last pixel of a frame.
- oUnderrun  out  1  sticky: a request arrived with no byte available.
- oSync_Err  out  1  sticky: iFrame_Start arrived with the pixel counter not at 0.

Behaviour:
- Reset (iRST_N low at a clock edge):
  - oPixel=0, oPix_Valid=0, oRD=0, oFrame_Done=0, oUnderrun=0, oSync_Err=0.
  - Internal state cleared: cur byte and cur_valid, nxt byte and nxt_valid, pending, bit phase cnt[2:0]=0, pixel counter=0.
- Storage is two bytes: cur (shifting) and nxt (prefetch).
- Prefetch: oRD is asserted for one cycle when nxt_valid=0 and pending=0. pending is set on that cycle; the next cycle loads nxt<=iRD_DATA[7:0], sets nxt_valid=1 and clears pending. Never more than one outstanding read.
- Promote: if cur_valid=0 and nxt_valid=1, then cur<=nxt, cur_valid=1, nxt_valid=0, cnt=0. The freed nxt slot re-triggers prefetch.
- After reset: oRD at cycle 1, nxt valid at 2, cur valid and second oRD at 3, nxt valid at 4. First pixel is servable from cycle 3.
- Request served (iRequest=1, cur_valid=1):
  - Selected bit = cur[cnt] if LSB_FIRST=1, else cur[7-cnt].
  - Next cycle: oPixel = {PIX_W{bit}}, oPix_Valid=1; cnt increments.
  - When cnt==7: cnt wraps to 0. If nxt_valid, cur<=nxt in the same edge (zero-bubble, back-to-back); otherwise cur_valid=0.
- Request with cur_valid=0: oPixel=0, oPix_Valid=1, oUnderrun set; cnt is unchanged.
- Pixel counter: advances on every request, served or underrun. On reaching PIX_PER_FRAME-1 with a request, oFrame_Done pulses alongside that pixel's oPix_Valid and the counter wraps to 0.
- iFrame_Start has priority over a same-cycle request:
  - If pixel counter != 0: set oSync_Err and force the counter to 0.
  - If cnt != 0: discard the rest of cur (cur_valid=0, cnt=0). The same-cycle request is then served from nxt bit 0 (or bit 7 when LSB_FIRST=0), and nxt is promoted with cnt=1.
  - If cnt == 0: the byte is kept and the request proceeds normally.
- A read still pending when a discard occurs lands in nxt as normal; no data is dropped from the FIFO.
- Reset mid-operation discards all held bytes and any pending read. Upstream must reload the FIFO (RD2_LOAD) together with this reset.
- Sticky flags clear only on reset.

Decomposition:
- Shared package vga_pkg: PIX_PER_FRAME_DEF = 640*480, PACK_W = 8, constant for frame-counter width (19 bits).
- One natural sub-module, bit_unpack_slot: the cur register, the cnt phase counter and bit selection. The top level holds prefetch, promote, frame counting and flags.

Test Plan:
- Reset, then continuous iRequest from cycle 3; FIFO supplies 8'h01, 8'hFE, 8'hAA.
  - Required: oPixel sequence 3FF,000×7, 000,3FF×7, 000,3FF,000,3FF,000,3FF,000,3FF.
  - No gaps in oPix_Valid; oUnderrun=0.
- LSB_FIRST=0, byte 8'h80 → first pixel 3FF, then 000×7.
- Requests starting at cycle 1 after reset → oPix_Valid with oPixel=0 at cycle 2, and oUnderrun stays 1 thereafter.
- PIX_PER_FRAME=64, 64 continuous requests → oFrame_Done pulses exactly once, with the 64th oPix_Valid. oSync_Err stays 0 when iFrame_Start accompanies request 65.
- iFrame_Start after 3 requests (cnt=3), next byte 8'h01:
  - oSync_Err=1.
  - Pixel emitted that cycle is 3FF (nxt bit 0); the remaining 5 bits of the old byte are never output.
- oRD audit over 1000 random request patterns: never more than one oRD per two cycles, and oRD count equals bytes consumed + prefetched (≤ 2 held).
